// File: rtl/fighter_control.sv
// Per-player fighter state: walking, jump physics, attack timing and combo detection,
// all advanced on a divided frame tick. Every output comes straight from a flop.
module fighter_control #(
    parameter int TICK_DIV      = 1_666_666,
    parameter int X_MIN         = 8,
    parameter int X_MAX         = 88,
    parameter int X_START       = 24,
    parameter int Y_GROUND      = 40,
    parameter int SPEED         = 1,
    parameter int JUMP_V        = 6,
    parameter int GRAVITY       = 1,
    parameter int MIRROR_START  = 0,
    parameter int ATTACK_TICKS  = 12,
    parameter int SPECIAL_TICKS = 24,
    parameter int SUPER_TICKS   = 48,
    parameter int COMBO_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_attack,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic       mirror,
    output logic       in_air,
    output logic       is_moving,
    output logic [1:0] character_state
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DUR_W  = $clog2(SUPER_TICKS + 1);
    localparam int IDLE_W = $clog2(COMBO_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(COMBO_TIMEOUT - 1);
    localparam logic signed [8:0] X_MIN_S    = 9'(X_MIN);
    localparam logic signed [8:0] X_MAX_S    = 9'(X_MAX);
    localparam logic signed [8:0] Y_GROUND_S = 9'(Y_GROUND);
    localparam logic signed [8:0] SPEED_S    = 9'(SPEED);
    localparam logic signed [8:0] JUMP_V_S   = 9'(JUMP_V);
    localparam logic signed [8:0] GRAVITY_S  = 9'(GRAVITY);
    localparam logic [6:0]        X_START_V  = 7'(X_START);
    localparam logic [6:0]        Y_GROUND_V = 7'(Y_GROUND);
    localparam logic              MIRROR_V   = 1'(MIRROR_START);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ATTACK  = 2'b01,
        ST_SPECIAL = 2'b10,
        ST_SUPER   = 2'b11
    } state_t;

    localparam logic [2:0] H_NONE = 3'd0;
    localparam logic [2:0] H_L    = 3'd1;
    localparam logic [2:0] H_R    = 3'd2;
    localparam logic [2:0] H_U    = 3'd3;
    localparam logic [2:0] H_D    = 3'd4;

    // History index 0 is the newest entry, so the oldest combo step sits in the MSBs.
    localparam logic [23:0] SUPER_SEQ   = {H_U, H_D, H_U, H_D, H_L, H_R, H_L, H_R};
    localparam logic [8:0]  SPECIAL_SEQ = {H_L, H_D, H_R};

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         btn_prev_q, btn_prev_d;
    logic [6:0]         x_q, x_d, y_q, y_d;
    logic signed [8:0]  vy_q, vy_d;
    logic               in_air_q, in_air_d;
    logic               is_moving_q, is_moving_d;
    logic               mirror_q, mirror_d;
    state_t             state_q, state_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [7:0][2:0]    hist_q, hist_d;

    logic               tick;
    logic [4:0]         btn_now, press;
    logic [2:0]         dir_code;
    logic signed [8:0]  x_s, y_s;

    // Button bit order: 0 left, 1 right, 2 up, 3 down, 4 attack.
    assign btn_now = {btn_attack, btn_down, btn_up, btn_right, btn_left};
    assign press   = btn_now & ~btn_prev_q;
    assign tick    = (cnt_q == CNT_LAST);

    always_comb begin
        dir_code = H_NONE;
        if (press[0])      dir_code = H_L;
        else if (press[1]) dir_code = H_R;
        else if (press[2]) dir_code = H_U;
        else if (press[3]) dir_code = H_D;
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        btn_prev_d  = btn_now;
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        in_air_d    = in_air_q;
        is_moving_d = is_moving_q;
        mirror_d    = mirror_q;
        state_d     = state_q;
        dur_d       = dur_q;
        idle_d      = idle_q;
        hist_d      = hist_q;
        x_s         = '0;
        y_s         = '0;

        if (tick) begin
            if (state_q == ST_IDLE && (btn_left ^ btn_right)) begin
                x_s = btn_left ? ($signed({2'b00, x_q}) - SPEED_S)
                               : ($signed({2'b00, x_q}) + SPEED_S);
                if (x_s < X_MIN_S)      x_d = X_MIN_S[6:0];
                else if (x_s > X_MAX_S) x_d = X_MAX_S[6:0];
                else                    x_d = x_s[6:0];
                mirror_d    = btn_left;
                is_moving_d = 1'b1;
            end else begin
                is_moving_d = 1'b0;
            end
        end

        // Launch takes effect on the next clock; a tick in the launch cycle does not move y.
        if (!in_air_q && press[2]) begin
            vy_d     = -JUMP_V_S;
            in_air_d = 1'b1;
        end else if (in_air_q && tick) begin
            y_s  = $signed({2'b00, y_q}) + vy_q;
            vy_d = vy_q + GRAVITY_S;
            if (y_s >= Y_GROUND_S) begin
                y_d      = Y_GROUND_V;
                vy_d     = '0;
                in_air_d = 1'b0;
            end else if (y_s < 9'sd0) begin
                y_d = '0;
            end else begin
                y_d = y_s[6:0];
            end
        end

        if (state_q == ST_IDLE && press[4]) begin
            if (hist_q == SUPER_SEQ) begin
                state_d = ST_SUPER;
                dur_d   = DUR_W'(SUPER_TICKS);
            end else if (hist_q[2:0] == SPECIAL_SEQ) begin
                state_d = ST_SPECIAL;
                dur_d   = DUR_W'(SPECIAL_TICKS);
            end else begin
                state_d = ST_ATTACK;
                dur_d   = DUR_W'(ATTACK_TICKS);
            end
            hist_d = '0;
            idle_d = '0;
        end else begin
            if (state_q != ST_IDLE && tick) begin
                if (dur_q <= DUR_W'(1)) begin
                    state_d = ST_IDLE;
                    dur_d   = '0;
                end else begin
                    dur_d = dur_q - 1'b1;
                end
            end
            if (dir_code != H_NONE) begin
                hist_d = {hist_q[6:0], dir_code};
                idle_d = '0;
            end else if (tick) begin
                if (idle_q == IDLE_LAST) begin
                    hist_d = '0;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            btn_prev_q  <= '0;
            x_q         <= X_START_V;
            y_q         <= Y_GROUND_V;
            vy_q        <= '0;
            in_air_q    <= 1'b0;
            is_moving_q <= 1'b0;
            mirror_q    <= MIRROR_V;
            state_q     <= ST_IDLE;
            dur_q       <= '0;
            idle_q      <= '0;
            hist_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            btn_prev_q  <= btn_prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            in_air_q    <= in_air_d;
            is_moving_q <= is_moving_d;
            mirror_q    <= mirror_d;
            state_q     <= state_d;
            dur_q       <= dur_d;
            idle_q      <= idle_d;
            hist_q      <= hist_d;
        end
    end

    assign x               = x_q;
    assign y               = y_q;
    assign mirror          = mirror_q;
    assign in_air          = in_air_q;
    assign is_moving       = is_moving_q;
    assign character_state = state_q;

endmodule

// File: tb/tb_fighter_control.sv
// Bench for fighter_control: directed scenarios plus random button traffic, with every
// cycle compared against a behavioural model of the fighter rules.
module tb_fighter_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_attack = 1'b0;
    logic [6:0] x, y;
    logic       mirror, in_air, is_moving;
    logic [1:0] character_state;

    fighter_control #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_attack(btn_attack),
        .x(x), .y(y), .mirror(mirror), .in_air(in_air),
        .is_moving(is_moving), .character_state(character_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt = 0, m_x = 24, m_y = 40, m_vy = 0, m_air = 0, m_mov = 0, m_mir = 0;
    int m_st = 0, m_rem = 0, m_idle = 0;
    int m_hist[$];
    bit [4:0] m_prev = '0;
    bit m_tick_last = 1'b0;
    int super_pat[8] = '{3, 4, 3, 4, 1, 2, 1, 2};

    function automatic bit is_super();
        if (m_hist.size() != 8) return 1'b0;
        for (int i = 0; i < 8; i++) if (m_hist[i] != super_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit is_special();
        int n;
        n = m_hist.size();
        if (n < 3) return 1'b0;
        return (m_hist[n-3] == 1) && (m_hist[n-2] == 4) && (m_hist[n-1] == 2);
    endfunction

    always @(posedge clk) begin : model
        bit tk;
        bit [4:0] cur, pr;
        int code, st0, air0, nx, yn;
        if (!rst_n) begin
            m_cnt = 0; m_x = 24; m_y = 40; m_vy = 0; m_air = 0; m_mov = 0; m_mir = 0;
            m_st = 0; m_rem = 0; m_idle = 0; m_hist.delete(); m_prev = '0; m_tick_last = 1'b0;
        end else begin
            tk = (m_cnt == 3);
            m_tick_last = tk;
            m_cnt = tk ? 0 : m_cnt + 1;
            cur = {btn_attack, btn_down, btn_up, btn_right, btn_left};
            pr = cur & ~m_prev;
            m_prev = cur;
            st0 = m_st;
            air0 = m_air;
            if (tk) begin
                if (st0 == 0 && (btn_left != btn_right)) begin
                    nx = m_x + (btn_left ? -1 : 1);
                    if (nx < 8) nx = 8;
                    if (nx > 88) nx = 88;
                    m_x = nx; m_mir = btn_left; m_mov = 1;
                end else m_mov = 0;
            end
            if (air0 == 0 && pr[2]) begin
                m_vy = -6; m_air = 1;
            end else if (air0 == 1 && tk) begin
                yn = m_y + m_vy;
                m_vy = m_vy + 1;
                if (yn >= 40) begin m_y = 40; m_vy = 0; m_air = 0; end
                else m_y = (yn < 0) ? 0 : yn;
            end
            code = pr[0] ? 1 : pr[1] ? 2 : pr[2] ? 3 : pr[3] ? 4 : 0;
            if (st0 == 0 && pr[4]) begin
                if (is_super()) begin m_st = 3; m_rem = 48; end
                else if (is_special()) begin m_st = 2; m_rem = 24; end
                else begin m_st = 1; m_rem = 12; end
                m_hist.delete();
                m_idle = 0;
            end else begin
                if (st0 != 0 && tk) begin
                    m_rem--;
                    if (m_rem == 0) m_st = 0;
                end
                if (code != 0) begin
                    m_hist.push_back(code);
                    if (m_hist.size() > 8) void'(m_hist.pop_front());
                    m_idle = 0;
                end else if (tk) begin
                    m_idle++;
                    if (m_idle == 30) begin m_hist.delete(); m_idle = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outs", {13'd0, x, y, mirror, in_air, is_moving, character_state},
                  32'((m_x << 12) | (m_y << 5) | (m_mir << 4) | (m_air << 3) | (m_mov << 2) | m_st));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tick_last && n < 16);
        if (!m_tick_last) check("tick_timeout", 0, 1);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_left = v;
            1: btn_right = v;
            2: btn_up = v;
            3: btn_down = v;
            default: btn_attack = v;
        endcase
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
        @(negedge clk);
    endtask

    task automatic release_all();
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_attack = 0;
    endtask

    task automatic press_attack();
        btn_attack = 1'b1;
        @(negedge clk);
        btn_attack = 1'b0;
    endtask

    int jump_y[13] = '{34, 29, 25, 22, 20, 19, 19, 20, 22, 25, 29, 34, 40};
    int left_x[3]  = '{9, 8, 8};
    int super_btn[8] = '{2, 3, 2, 3, 0, 1, 0, 1};

    initial begin : stim
        logic [6:0] x0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_x", x, 24);
        check("rst_y", y, 40);
        check("rst_state", character_state, 0);
        check("rst_mirror", mirror, 0);
        rst_n = 1'b1;

        btn_right = 1'b1;
        repeat (5) next_tick();
        check("walk_r_x", x, 29);
        check("walk_r_moving", is_moving, 1);
        check("walk_r_mirror", mirror, 0);
        btn_right = 1'b0;
        btn_left = 1'b1;
        repeat (19) next_tick();
        check("walk_l_x10", x, 10);
        for (int i = 0; i < 3; i++) begin
            next_tick();
            check("walk_l_clamp_x", x, 32'(left_x[i]));
            check("walk_l_mirror", mirror, 1);
        end
        check("walk_clamp_moving", is_moving, 1);
        btn_left = 1'b0;

        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        check("jump_start_air", in_air, 1);
        for (int i = 0; i < 13; i++) begin
            next_tick();
            check("jump_y", y, 32'(jump_y[i]));
            if (i == 11) check("jump_air_before_land", in_air, 1);
        end
        check("jump_landed", in_air, 0);

        press_attack();
        check("atk_enter", character_state, 1);
        x0 = x;
        for (int i = 1; i <= 12; i++) begin
            next_tick();
            if (i == 2) begin btn_attack = 1'b1; btn_right = 1'b1; end
            if (i == 3) btn_attack = 1'b0;
            if (i == 10) begin
                check("atk_x_frozen", x, 32'(x0));
                check("atk_not_moving", is_moving, 0);
                btn_right = 1'b0;
            end
            if (i == 11) check("atk_still", character_state, 1);
        end
        check("atk_done", character_state, 0);

        tap(0); tap(3); tap(1);
        press_attack();
        check("special_enter", character_state, 2);
        for (int i = 1; i <= 24; i++) begin
            next_tick();
            if (i == 23) check("special_still", character_state, 2);
        end
        check("special_done", character_state, 0);

        for (int i = 0; i < 8; i++) tap(super_btn[i]);
        press_attack();
        check("super_enter", character_state, 3);
        for (int i = 1; i <= 48; i++) begin
            next_tick();
            if (i == 47) check("super_still", character_state, 3);
        end
        check("super_done", character_state, 0);

        tap(0); tap(3);
        repeat (31) next_tick();
        tap(1);
        press_attack();
        check("timeout_plain_atk", character_state, 1);
        repeat (12) next_tick();

        btn_left = 1'b1; btn_right = 1'b1;
        @(negedge clk);
        release_all();
        @(negedge clk);
        tap(3); tap(1);
        press_attack();
        check("lr_same_records_l", character_state, 2);
        repeat (24) next_tick();

        tap(2);
        press_attack();
        repeat (3) next_tick();
        check("pre_rst_air", in_air, 1);
        check("pre_rst_state", character_state, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_x", x, 24);
        check("mid_rst_y", y, 40);
        check("mid_rst_air", in_air, 0);
        check("mid_rst_state", character_state, 0);
        rst_n = 1'b1;

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(4, 40)) begin
                        if ($urandom_range(0, 5) == 0) btn_left = ~btn_left;
                        if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
                        if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
                        if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
                        if ($urandom_range(0, 9) == 0) btn_attack = ~btn_attack;
                        @(negedge clk);
                    end
                end
                1: begin
                    release_all();
                    @(negedge clk);
                    tap(0); tap(3); tap(1);
                    press_attack();
                end
                2: begin
                    release_all();
                    @(negedge clk);
                    for (int i = 0; i < 8; i++) tap(super_btn[i]);
                    press_attack();
                end
                default: begin
                    release_all();
                    repeat ($urandom_range(1, 35)) next_tick();
                end
            endcase
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        release_all();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
